// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared core types for the fetch/data memory arbiter
package mem_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } prio_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and data requesters
// Data wins ties until fetch has waited STARVE_MAX data grants, then fetch gets one turn.
module mem_arbiter #(
    parameter int XLEN       = mem_arbiter_pkg::XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic            d_wen,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            m_en,
    output logic [XLEN-1:0] m_addr,
    output logic            m_wen,
    output logic [XLEN-1:0] m_wdata,
    input  logic [XLEN-1:0] m_rdata
);
    import mem_arbiter_pkg::*;

    localparam int CW = $clog2(STARVE_MAX + 1);

    prio_e          prio_q, prio_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    owner_e         own_q, own_d;
    logic           grant_i, grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= PRIO_D;
            cnt_q  <= '0;
            own_q  <= OWN_NONE;
        end else begin
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
            own_q  <= own_d;
        end
    end

    // Saturate so the counter can never wrap past the threshold.
    assign cnt_inc = (cnt_q == CW'(STARVE_MAX)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        prio_d = prio_q;
        cnt_d  = cnt_q;
        if (grant_i || !i_req) begin
            cnt_d = '0;
        end else if (grant_d) begin
            cnt_d = cnt_inc;
        end
        case (prio_q)
            PRIO_D: if (grant_d && i_req && cnt_inc == CW'(STARVE_MAX)) prio_d = PRIO_I;
            PRIO_I: if (grant_i) prio_d = PRIO_D;
            default: prio_d = PRIO_D;
        endcase
        if (grant_i) begin
            own_d = OWN_FETCH;
        end else if (grant_d) begin
            own_d = OWN_DATA;
        end else begin
            own_d = OWN_NONE;
        end
    end

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                grant_i = (prio_q == PRIO_I);
                grant_d = (prio_q == PRIO_D);
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    assign i_gnt   = grant_i;
    assign d_gnt   = grant_d;
    assign m_en    = grant_i | grant_d;
    assign m_addr  = grant_i ? i_addr : (grant_d ? d_addr : '0);
    assign m_wen   = grant_d & d_wen;
    assign m_wdata = grant_d ? d_wdata : '0;

    // A response owed from before reset is dropped while rst is high.
    assign i_rvalid = (own_q == OWN_FETCH) && !rst;
    assign d_rvalid = (own_q == OWN_DATA) && !rst;
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a reference model
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_wen;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.XLEN(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous RAM behind the arbiter: read data one cycle after m_en.
    logic [31:0] ram [0:255];
    initial for (int k = 0; k < 256; k++) ram[k] = init_word(k);
    always @(posedge clk) begin
        if (m_en) begin
            if (m_wen) ram[m_addr[9:2]] <= m_wdata;
            else       m_rdata <= ram[m_addr[9:2]];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [int];
    bit          ref_fetch_turn = 0;
    int          ref_streak     = 0;
    int          pend           = 0;
    bit          pend_store     = 0;
    logic [31:0] pend_data      = '0;

    // Observations from the latest step, used by the directed checks
    logic        g_i, g_d, rv_i, rv_d, o_mwen;
    logic [31:0] o_maddr, o_mwdata, o_drdata, o_irdata;

    function automatic logic [31:0] ref_read(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic dw, input logic [31:0] dd,
                        input logic rs);
        bit eg_i, eg_d, ev_i, ev_d;
        rst = rs; i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wen = dw; d_wdata = dd;
        @(negedge clk);
        eg_i = 0; eg_d = 0;
        if (!rs) begin
            if (ir && dr) begin
                eg_i = ref_fetch_turn;
                eg_d = !ref_fetch_turn;
            end else begin
                eg_i = ir;
                eg_d = dr;
            end
        end
        check_eq("i_gnt", 32'(i_gnt), 32'(eg_i));
        check_eq("d_gnt", 32'(d_gnt), 32'(eg_d));
        check_eq("m_en", 32'(m_en), 32'(eg_i | eg_d));
        if (eg_i) begin
            check_eq("m_addr_i", m_addr, ia);
            check_eq("m_wen_i", 32'(m_wen), 0);
        end else if (eg_d) begin
            check_eq("m_addr_d", m_addr, da);
            check_eq("m_wen_d", 32'(m_wen), 32'(dw));
            if (dw) check_eq("m_wdata", m_wdata, dd);
        end else begin
            check_eq("m_wen_idle", 32'(m_wen), 0);
        end
        ev_i = !rs && pend == 1;
        ev_d = !rs && pend == 2;
        check_eq("i_rvalid", 32'(i_rvalid), 32'(ev_i));
        check_eq("d_rvalid", 32'(d_rvalid), 32'(ev_d));
        check_eq("i_rdata", i_rdata, ev_i ? pend_data : 32'h0);
        if (!ev_d) check_eq("d_rdata_idle", d_rdata, 32'h0);
        else if (!pend_store) check_eq("d_rdata", d_rdata, pend_data);
        g_i = i_gnt; g_d = d_gnt; rv_i = i_rvalid; rv_d = d_rvalid;
        o_mwen = m_wen; o_maddr = m_addr; o_mwdata = m_wdata; o_drdata = d_rdata; o_irdata = i_rdata;
        pend = 0;
        if (rs) begin
            ref_fetch_turn = 0;
            ref_streak     = 0;
        end else if (eg_i) begin
            pend = 1; pend_data = ref_read(int'(ia[9:2]));
            ref_streak = 0; ref_fetch_turn = 0;
        end else if (eg_d) begin
            pend = 2; pend_store = dw; pend_data = ref_read(int'(da[9:2]));
            if (dw) ref_mem[int'(da[9:2])] = dd;
            if (ir) begin
                ref_streak++;
                if (ref_streak >= STARVE_MAX) ref_fetch_turn = 1;
            end else begin
                ref_streak = 0;
            end
        end else begin
            ref_streak = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic rs);
        step(0, 0, 0, 0, 0, 0, rs);
    endtask

    initial begin
        rst = 1; i_req = 0; d_req = 0; d_wen = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        @(posedge clk); #1;

        step(1, 32'h40, 1, 32'h80, 0, 0, 1);
        check_eq("rst_gnt_suppr", 32'({g_i, g_d}), 0);
        idle(0);
        check_eq("post_rst_rv", 32'({rv_i, rv_d}), 0);

        for (int k = 0; k < 3; k++) begin
            step(1, 32'(4 * k), 0, 0, 0, 0, 0);
            check_eq("fetch_only_gnt", 32'({g_i, g_d}), 32'b10);
        end
        idle(0);
        check_eq("fetch_only_rdata", o_irdata, init_word(2));

        idle(1);
        step(1, 32'h10, 1, 32'h100, 0, 0, 0);
        check_eq("tie_gnt", 32'({g_i, g_d}), 32'b01);
        check_eq("tie_maddr", o_maddr, 32'h100);
        step(1, 32'h10, 0, 0, 0, 0, 0);
        check_eq("tie_drvalid", 32'(rv_d), 1);
        idle(0);

        idle(1);
        for (int k = 0; k < 10; k++) begin
            step(1, 32'h200, 1, 32'h300, 0, 0, 0);
            check_eq("starve_pat", 32'({g_i, g_d}), (k % 5 == 4) ? 32'b10 : 32'b01);
        end
        idle(0);

        step(0, 0, 1, 32'h20, 1, 32'hDEAD_BEEF, 0);
        check_eq("store_wen", 32'(o_mwen), 1);
        check_eq("store_wdata", o_mwdata, 32'hDEAD_BEEF);
        step(0, 0, 1, 32'h20, 0, 0, 0);
        check_eq("store_ack", 32'(rv_d), 1);
        idle(0);
        check_eq("load_back", o_drdata, 32'hDEAD_BEEF);

        step(1, 32'hC, 0, 0, 0, 0, 0);
        step(1, 32'hC, 0, 0, 0, 0, 1);
        check_eq("rst_midop_rv1", 32'(rv_i), 0);
        idle(0);
        check_eq("rst_midop_rv2", 32'(rv_i), 0);
        for (int k = 0; k < 3; k++) step(1, 32'h44, 1, 32'h88, 0, 0, 0);
        idle(1);
        for (int k = 0; k < 5; k++) begin
            step(1, 32'h44, 1, 32'h88, 0, 0, 0);
            check_eq("rst_cnt_clear", 32'({g_i, g_d}), (k == 4) ? 32'b10 : 32'b01);
        end
        idle(0);

        step(1, 32'h50, 1, 32'h60, 0, 0, 0);
        check_eq("withdraw_gnt", 32'({g_i, g_d}), 32'b01);
        idle(0);
        check_eq("withdraw_irv1", 32'(rv_i), 0);
        idle(0);
        check_eq("withdraw_irv2", 32'(rv_i), 0);

        for (int k = 0; k < 500; k++) begin
            step(($urandom % 4) != 0, {22'h0, 8'($urandom), 2'b00},
                 ($urandom % 4) != 0, {22'h0, 8'($urandom), 2'b00},
                 ($urandom % 3) == 0, $urandom, ($urandom % 60) == 0);
        end
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: XLEN, 32, data/address width.
REQ-002 SHALL have parameter: STARVE_MAX, 4, max consecutive data grants while fetch waits.
REQ-003 SHALL have ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- i_req  in  1  fetch request.
- i_addr  in  XLEN  fetch byte address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  XLEN  fetch read data.
- d_req  in  1  data request.
- d_addr  in  XLEN  data byte address.
- d_wen  in  1  data write enable (1=store, 0=load).
- d_wdata  in  XLEN  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid / store acknowledge.
- d_rdata  out  XLEN  load data.
- m_en  out  1  memory access strobe.
- m_addr  out  XLEN  memory address.
- m_wen  out  1  memory write enable.
- m_wdata  out  XLEN  memory write data.
- m_rdata  in  XLEN  memory read data, valid one cycle after m_en.

Function
REQ-004 SHALL grant at most one of i_gnt/d_gnt per cycle; grant decision combinational from req inputs and registered priority state.
REQ-005 SHALL assert m_en in the grant cycle, with m_addr/m_wen/m_wdata taken from the granted port; m_wen=0 for fetch grants; m_en=0, m_wen=0 when nothing granted.
REQ-006 SHALL assert the granted port's rvalid exactly one cycle after its grant, with rdata = m_rdata passed through combinationally that cycle.
REQ-007 SHALL pulse d_rvalid for stores as acknowledge; d_rdata is don't-care for store responses.
REQ-008 SHALL support back-to-back grants (one per cycle, any port mix) with no bubble.
REQ-009 SHALL hold rdata outputs at 0 when rvalid is low.
REQ-010 SHALL run a 2-state priority FSM: PRIO_D (data wins ties) and PRIO_I (fetch wins ties).
REQ-011 SHALL keep a starvation counter (width clog2(STARVE_MAX+1)): increment on each d_gnt while i_req=1; clear on any i_gnt or when i_req=0.
REQ-012 SHALL transition PRIO_D->PRIO_I when a d_gnt makes the counter reach STARVE_MAX; PRIO_I->PRIO_D after the next i_gnt.
REQ-013 SHALL, with only one requester active, grant it every cycle regardless of FSM state.
REQ-014 SHALL treat requesters as holding req/addr/wen/wdata stable until gnt; deasserting req before gnt SHALL be legal (request withdrawn, no response).
REQ-015 SHALL track the in-flight response owner in a 2-bit register {none, fetch, data}, loaded every cycle from the grant.

Reset
REQ-016 SHALL, on rst=1 at a clk edge: FSM=PRIO_D, counter=0, in-flight owner=none.
REQ-017 SHALL drive i_rvalid=0, d_rvalid=0 in the cycle after reset even if a grant occurred in the reset cycle; grants during rst=1 SHALL be suppressed (i_gnt=d_gnt=m_en=0).

Structure
REQ-018 SHALL place the in-flight owner encoding and the FSM state encoding in the shared core package alongside XLEN.
REQ-019 SHALL be one flat module; no sub-module is required.

Verification
REQ-020 Fetch only: i_req=1, i_addr=0x0,0x4,0x8 consecutive -> i_gnt each cycle, i_rvalid with memory words in the following cycles, d_gnt=0 throughout.
REQ-021 Tie: i_req=d_req=1 after reset, d_addr=0x100 load -> d_gnt first cycle, m_addr=0x100, m_wen=0, d_rvalid next cycle.
REQ-022 Starvation: both req held, STARVE_MAX=4 -> d_gnt 4 cycles, i_gnt 5th cycle, then d_gnt resumes (pattern D,D,D,D,I repeating).
REQ-023 Store: d_req=1, d_wen=1, d_addr=0x20, d_wdata=0xDEADBEEF -> m_wen=1, m_wdata=0xDEADBEEF in grant cycle, d_rvalid ack next cycle; subsequent load of 0x20 returns 0xDEADBEEF.
REQ-024 Reset mid-op: grant fetch at cycle N, rst=1 at cycle N+1 -> i_rvalid=0 at N+1 and N+2, FSM back to PRIO_D, counter 0.
REQ-025 Withdrawal: i_req pulses 1 cycle while losing to d_req -> no i_rvalid ever issued for it.
